// File: rtl/debounce_scan_ctrl.sv
// Multi-channel switch debouncer sharing one sample timebase, with a round-robin event arbiter.
// Define DB_SCAN_FALL_EVT_EN to post falling-edge events as well as rising ones.
module debounce_scan_ctrl #(
    parameter  int ClkRate     = 10_000_000,
    parameter  int Baud        = 10_000,
    parameter  int NumCh       = 4,
    parameter  int StableTicks = 4,
    localparam int TickDiv     = ClkRate / Baud,
    localparam int CntW        = $clog2(TickDiv),
    localparam int StabW       = $clog2(StableTicks),
    localparam int ChW         = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumCh-1:0] sw_i,
    output logic [NumCh-1:0] db_level_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [ChW-1:0]   evt_ch_o,
    output logic             evt_rise_o,
    input  logic             ovf_clr_i,
    output logic             overflow_o,
    output logic             dbg_state_o
);

    // Handshake: an event transfers on a clock edge where evt_valid_o && evt_ready_i;
    // evt_valid_o is a pure function of registered state and never looks at evt_ready_i.
    typedef enum logic {S_IDLE = 1'b0, S_PRESENT = 1'b1} state_t;

    logic [CntW-1:0]             r_cnt;
    logic                        w_tick;
    logic [NumCh-1:0]            r_sync1, r_sync2, r_level, r_pend;
    logic [NumCh-1:0][StabW-1:0] r_stab;
    logic [NumCh-1:0]            w_accept, w_post, w_grant;
    logic [ChW:0]                w_pick;
    logic                        w_ovf_set;
    logic                        r_ovf;
    logic [ChW-1:0]              r_last, r_evt_ch;
    state_t                      r_state, w_state_nxt;

    assign w_tick = (r_cnt == CntW'(TickDiv - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)       r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

    // A change is accepted on the StableTicks-th consecutive differing sample.
    always_comb begin
        w_accept = '0;
        for (int c = 0; c < NumCh; c++)
            w_accept[c] = w_tick && (r_sync2[c] != r_level[c]) &&
                          (r_stab[c] == StabW'(StableTicks - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_stab  <= '0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                for (int c = 0; c < NumCh; c++) begin
                    if (r_sync2[c] == r_level[c]) begin
                        r_stab[c] <= '0;
                    end else if (w_accept[c]) begin
                        r_stab[c]  <= '0;
                        r_level[c] <= ~r_level[c];
                    end else begin
                        r_stab[c] <= r_stab[c] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef DB_SCAN_FALL_EVT_EN
    assign w_post = w_accept;
`else
    assign w_post = w_accept & ~r_level;
`endif

    // Returns {found, index}: first pending channel after 'last', wrapping around.
    function automatic logic [ChW:0] f_pick(input logic [NumCh-1:0] pend,
                                            input logic [ChW-1:0] last);
        int             idx;
        logic [ChW-1:0] sel;
        f_pick = '0;
        for (int i = 1; i <= NumCh; i++) begin
            idx = int'(last) + i;
            if (idx >= NumCh) idx = idx - NumCh;
            sel = ChW'(idx);
            if (!f_pick[ChW] && pend[sel]) f_pick = {1'b1, sel};
        end
    endfunction

    always_comb begin
        w_pick      = f_pick(r_pend, r_last);
        w_state_nxt = r_state;
        w_grant     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick[ChW]) begin
                    w_state_nxt              = S_PRESENT;
                    w_grant[w_pick[ChW-1:0]] = 1'b1;
                end
            end
            S_PRESENT: if (evt_ready_i) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // A post in the same cycle as a grant of that channel re-arms it without overflow.
    assign w_ovf_set = |(w_post & r_pend & ~w_grant);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_last   <= '0;
            r_evt_ch <= '0;
            r_pend   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (|w_grant) begin
                r_evt_ch <= w_pick[ChW-1:0];
                r_last   <= w_pick[ChW-1:0];
            end
            r_pend <= (r_pend & ~w_grant) | w_post;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (ovf_clr_i) r_ovf <= 1'b0;
        end
    end

`ifdef DB_SCAN_FALL_EVT_EN
    logic [NumCh-1:0] r_pol;
    logic             r_evt_rise;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pol      <= '0;
            r_evt_rise <= 1'b0;
        end else begin
            r_pol <= (r_pol & ~w_post) | (w_post & ~r_level);
            if (|w_grant) r_evt_rise <= r_pol[w_pick[ChW-1:0]];
        end
    end

    assign evt_rise_o = r_evt_rise;
`else
    assign evt_rise_o = 1'b1;
`endif

    assign db_level_o  = r_level;
    assign evt_valid_o = (r_state == S_PRESENT);
    assign evt_ch_o    = r_evt_ch;
    assign overflow_o  = r_ovf;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl: directed scenarios plus random switch activity, checked
// against a transaction-level reference model through an expected-event queue.
module tb_debounce_scan_ctrl;

    localparam int CLK_RATE = 100;
    localparam int BAUD     = 10;
    localparam int NCH      = 4;
    localparam int ST       = 3;
    localparam int TDIV     = CLK_RATE / BAUD;
`ifdef DB_SCAN_FALL_EVT_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [NCH-1:0] sw;
    logic [NCH-1:0] db_level;
    logic           evt_valid;
    logic           evt_ready;
    logic [1:0]     evt_ch;
    logic           evt_rise;
    logic           ovf_clr;
    logic           overflow;
    logic           dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0] exp_q[$];

    debounce_scan_ctrl #(
        .ClkRate    (CLK_RATE),
        .Baud       (BAUD),
        .NumCh      (NCH),
        .StableTicks(ST)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_i       (sw),
        .db_level_o (db_level),
        .evt_valid_o(evt_valid),
        .evt_ready_i(evt_ready),
        .evt_ch_o   (evt_ch),
        .evt_rise_o (evt_rise),
        .ovf_clr_i  (ovf_clr),
        .overflow_o (overflow),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: samples seen two edges late, a level flips after ST consecutive
    // disagreeing samples, events sit in per-channel slots, one is offered at a time
    logic [NCH-1:0] m_h1, m_h2, m_level, m_pend, m_pol, m_posts;
    int             m_run[NCH];
    int             m_n;
    int             m_idx, m_base;
    logic           m_ovf, m_valid, m_set, m_found;
    logic [1:0]     m_last;
    logic           m_started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_level = '0; m_pend = '0; m_pol = '0;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
            m_n = 0; m_ovf = 1'b0; m_valid = 1'b0; m_last = '0;
            exp_q.delete();
            m_started = 1'b1;
        end else begin
            m_n++;
            m_posts = '0;
            if (m_n % TDIV == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    if (m_h2[c] == m_level[c]) begin
                        m_run[c] = 0;
                    end else begin
                        m_run[c]++;
                        if (m_run[c] == ST) begin
                            m_level[c] = ~m_level[c];
                            m_run[c]   = 0;
                            if (FALL_EN || m_level[c]) m_posts[c] = 1'b1;
                        end
                    end
                end
            end
            if (m_valid) begin
                if (evt_ready) m_valid = 1'b0;
            end else begin
                m_found = 1'b0;
                m_base  = int'(m_last);
                for (int k = 1; k <= NCH; k++) begin
                    m_idx = (m_base + k) % NCH;
                    if (!m_found && m_pend[m_idx]) begin
                        m_found       = 1'b1;
                        m_last        = 2'(m_idx);
                        m_pend[m_idx] = 1'b0;
                        m_valid       = 1'b1;
                        exp_q.push_back({2'(m_idx), m_pol[m_idx]});
                    end
                end
            end
            m_set = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (m_posts[c]) begin
                    if (m_pend[c]) m_set = 1'b1;
                    m_pend[c] = 1'b1;
                    m_pol[c]  = m_level[c];
                end
            end
            if (m_set)        m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_h2 = m_h1;
            m_h1 = sw;
        end
    end

    // scoreboard monitor
    logic [2:0] mon_exp;
    always @(negedge clk) begin
        if (m_started) begin
            chk("db_level", 32'(db_level), 32'(m_level));
            chk("evt_valid", 32'(evt_valid), 32'(m_valid));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL evt_unexpected: got ch=%0d rise=%0d expected none at %0t",
                             evt_ch, evt_rise, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("evt_ch", 32'(evt_ch), 32'(mon_exp[2:1]));
                    chk("evt_rise", 32'(evt_rise), 32'(mon_exp[0]));
                end
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    int  bit_sel;
    bit  hold_burst;
    int  waited;

    initial begin
        rst = 1'b1; sw = '1; evt_ready = 1'b1; ovf_clr = 1'b0;
        step(1);
        rst = 1'b0;
        step(45);
        sw = '0;
        step(45);

        do_reset();
        sw[0] = 1'b1;
        step(50);
        sw[1] = 1'b1;
        step(20);
        sw[1] = 1'b0;
        step(50);

        sw[2:1] = 2'b11;
        step(50);
        sw[2:1] = 2'b00;
        step(50);
        sw[3] = 1'b1; sw[1] = 1'b1;
        step(50);

        evt_ready = 1'b0;
        sw[0] = 1'b0; step(40);
        sw[0] = 1'b1; step(40);
        sw[2] = 1'b1; step(40);
        sw[0] = 1'b0; step(40);
        evt_ready = 1'b1;
        step(20);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(10);

        hold_burst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                bit_sel = $urandom_range(0, NCH - 1);
                sw[bit_sel] = ~sw[bit_sel];
            end
            if (i % 200 == 0) hold_burst = 1'($urandom_range(0, 1));
            evt_ready = hold_burst ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 63) == 0);
            step(1);
        end

        evt_ready = 1'b0; ovf_clr = 1'b0;
        sw = '0;
        step(60);
        sw = '1;
        waited = 0;
        while (waited < 100 && !evt_valid) begin
            step(1);
            waited++;
        end
        chk("pre_reset_valid", 32'(evt_valid), 32'd1);
        do_reset();
        evt_ready = 1'b1;
        step(60);

        waited = 0;
        while (waited < 300 && (exp_q.size() != 0 || m_pend != '0 || evt_valid)) begin
            step(1);
            waited++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
